// File: rtl/tile_seq_pkg.sv
// Shared types and constants for the tile operation sequencer.
package tile_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam logic [2:0] MODE_MAC      = 3'b000;
  localparam logic [2:0] MODE_EWM_MAT  = 3'b001;
  localparam logic [2:0] MODE_EWM_VEC  = 3'b010;
  localparam logic [2:0] MODE_EWM_OUT  = 3'b011;
  localparam logic [2:0] MODE_EWA_VEC  = 3'b100;
  localparam logic [2:0] MODE_EWA_MAT  = 3'b101;
  localparam logic [2:0] MODE_EWM_MAT2 = 3'b110;

  localparam int unsigned COL_BLOCKS_DEFAULT = 16;

endpackage

// File: rtl/seq_credit_ctr.sv
// Saturating result-buffer credit counter; starts full on reset.
module seq_credit_ctr #(
  parameter int unsigned CREDITS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic has_credit
);
  localparam int unsigned CW = $clog2(CREDITS + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= CW'(CREDITS);
    end else if (inc && !dec && count != CW'(CREDITS)) begin
      count <= count + CW'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign has_credit = (count != '0);

endmodule

// File: rtl/tile_op_sequencer.sv
// Walks one operation's tile grid row-major, issuing credit-gated fetch beats
// and tracking returned results and MAC tile completions.
module tile_op_sequencer
  import tile_seq_pkg::*;
#(
  parameter int unsigned COL_BLOCKS = COL_BLOCKS_DEFAULT,
  parameter int unsigned ROW_W      = 10,
  parameter int unsigned COL_W      = 8,
  parameter int unsigned CREDITS    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [ROW_W-1:0] cmd_rows,
  input  logic [COL_W-1:0] cmd_cols,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic [ROW_W-1:0] fetch_row,
  output logic [COL_W-1:0] fetch_col,
  output logic [2:0]       arr_mode,
  output logic             arr_valid_in,
  input  logic             arr_valid_out,
  input  logic             arr_done_tile,
  input  logic             credit_ret,
  output logic             busy,
  output logic             op_done,
  output logic             op_err
);
  localparam int unsigned CNT_W = ROW_W + COL_W;

  seq_state_t       state, state_nxt;
  logic [2:0]       mode_q;
  logic [ROW_W-1:0] rows_q, row_q, tiles_q;
  logic [COL_W-1:0] cols_q, col_q;
  logic [CNT_W-1:0] issued_q, returned_q, returned_nxt;
  logic             err_q, mac_chk_q, stray_q;
  logic             has_credit, accept, beat, counting;
  logic             last_col, last_beat, cmd_empty, cmd_bad;

  seq_credit_ctr #(.CREDITS(CREDITS)) u_credit (
    .clk        (clk),
    .rst        (rst),
    .inc        (credit_ret),
    .dec        (beat),
    .has_credit (has_credit)
  );

  assign accept       = cmd_valid && (state == IDLE);
  assign cmd_empty    = (cmd_rows == '0) || (cmd_cols == '0);
  assign cmd_bad      = (cmd_mode == MODE_MAC) && (cmd_cols != COL_W'(COL_BLOCKS));
  assign fetch_valid  = (state == ISSUE) && has_credit;
  assign arr_valid_in = fetch_valid && fetch_ready;
  assign beat         = arr_valid_in;
  assign counting     = (state == ISSUE) || (state == DRAIN);
  assign last_col     = (col_q == cols_q - COL_W'(1));
  assign last_beat    = last_col && (row_q == rows_q - ROW_W'(1));
  assign returned_nxt = returned_q + CNT_W'(arr_valid_out && counting);

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign op_done   = (state == DONE);
  assign op_err    = op_done && (err_q || stray_q || (mac_chk_q && tiles_q != rows_q));
  assign fetch_row = row_q;
  assign fetch_col = col_q;
  assign arr_mode  = mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Drain exit looks at the count including this cycle's return so op_done
  // lands in the cycle right after the final result.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_nxt = (cmd_empty || cmd_bad) ? DONE : ISSUE;
      ISSUE:   if (beat && last_beat) state_nxt = DRAIN;
      DRAIN:   if (returned_nxt == issued_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      tiles_q    <= '0;
      err_q      <= 1'b0;
      mac_chk_q  <= 1'b0;
    end else if (accept) begin
      mode_q     <= cmd_mode;
      rows_q     <= cmd_rows;
      cols_q     <= cmd_cols;
      row_q      <= '0;
      col_q      <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      tiles_q    <= '0;
      err_q      <= cmd_bad && !cmd_empty;
      mac_chk_q  <= (cmd_mode == MODE_MAC) && !cmd_empty;
    end else begin
      if (beat) begin
        issued_q <= issued_q + CNT_W'(1);
        if (last_col) begin
          col_q <= '0;
          row_q <= last_beat ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
      if (counting) returned_q <= returned_nxt;
      if (counting && mode_q == MODE_MAC && arr_done_tile) tiles_q <= tiles_q + ROW_W'(1);
    end
  end

  // A stray seen during DONE belongs to the following operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 stray_q <= 1'b0;
    else if (state == DONE)                  stray_q <= arr_valid_out;
    else if (state == IDLE && arr_valid_out) stray_q <= 1'b1;
  end

endmodule

// File: tb/tb_tile_op_sequencer.sv
// Scoreboard bench: stimulus queues expected beats/completions, a negedge monitor checks them.
module tb_tile_op_sequencer;
  localparam int ROW_W = 10;
  localparam int COL_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_mode;
  logic [ROW_W-1:0] cmd_rows;
  logic [COL_W-1:0] cmd_cols;
  logic             fetch_valid;
  logic             fetch_ready;
  logic [ROW_W-1:0] fetch_row;
  logic [COL_W-1:0] fetch_col;
  logic [2:0]       arr_mode;
  logic             arr_valid_in;
  logic             arr_valid_out;
  logic             arr_done_tile;
  logic             credit_ret;
  logic             busy;
  logic             op_done;
  logic             op_err;

  logic vo_pipe = 1'b0;
  logic dt_pipe = 1'b0;
  int   beat_n  = 0;
  int   dt_n    = 0;
  int   tiles_allowed;
  logic auto_credit;
  logic credit_man;
  logic stray_inj;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit is_done;
    int row;
    int col;
    int mode;
    bit err;
  } exp_t;

  exp_t exp_q[$];

  tile_op_sequencer #(
    .COL_BLOCKS (16),
    .ROW_W      (ROW_W),
    .COL_W      (COL_W),
    .CREDITS    (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_mode      (cmd_mode),
    .cmd_rows      (cmd_rows),
    .cmd_cols      (cmd_cols),
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .fetch_row     (fetch_row),
    .fetch_col     (fetch_col),
    .arr_mode      (arr_mode),
    .arr_valid_in  (arr_valid_in),
    .arr_valid_out (arr_valid_out),
    .arr_done_tile (arr_done_tile),
    .credit_ret    (credit_ret),
    .busy          (busy),
    .op_done       (op_done),
    .op_err        (op_err)
  );

  always #5 clk = ~clk;

  // Pipeline model: fixed latency 1; done_tile after every 16th beat up to tiles_allowed.
  always @(posedge clk) begin
    vo_pipe <= arr_valid_in;
    dt_pipe <= 1'b0;
    if (cmd_valid && cmd_ready) begin
      beat_n <= 0;
      dt_n   <= 0;
    end else if (arr_valid_in) begin
      beat_n <= beat_n + 1;
      if ((beat_n + 1) % 16 == 0 && dt_n < tiles_allowed) begin
        dt_pipe <= 1'b1;
        dt_n    <= dt_n + 1;
      end
    end
  end

  assign arr_valid_out = vo_pipe | stray_inj;
  assign arr_done_tile = dt_pipe;
  assign credit_ret    = (auto_credit & arr_valid_out) | credit_man;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (arr_valid_in) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", int'(fetch_row) * 1000 + int'(fetch_col) * 10 + int'(arr_mode), -1);
        end else begin
          e = exp_q.pop_front();
          check("beat_row_col_mode", int'(fetch_row) * 1000 + int'(fetch_col) * 10 + int'(arr_mode),
                e.is_done ? -1 : e.row * 1000 + e.col * 10 + e.mode);
        end
      end
      if (op_done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", int'(op_err), -1);
        end else begin
          e = exp_q.pop_front();
          check("done_err", int'(op_err), e.is_done ? int'(e.err) : -1);
        end
      end
    end
  end

  task automatic push_op(int mode, int rows, int cols, bit err);
    exp_t e;
    if (rows != 0 && cols != 0 && !(mode == 0 && cols != 16)) begin
      for (int r = 0; r < rows; r++) begin
        for (int c = 0; c < cols; c++) begin
          e.is_done = 1'b0; e.row = r; e.col = c; e.mode = mode; e.err = 1'b0;
          exp_q.push_back(e);
        end
      end
    end
    e.is_done = 1'b1; e.row = 0; e.col = 0; e.mode = mode; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic send_cmd(int mode, int rows, int cols);
    bit ok = 1'b0;
    cmd_mode  = 3'(mode);
    cmd_rows  = ROW_W'(rows);
    cmd_cols  = COL_W'(cols);
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!ok) check("cmd_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      check(name, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic check_reset(string name);
    check({name, "_ctrl"}, int'({cmd_ready, busy, fetch_valid, arr_valid_in, op_done, op_err}), 32);
    check({name, "_row"}, int'(fetch_row), 0);
    check({name, "_col"}, int'(fetch_col), 0);
    check({name, "_mode"}, int'(arr_mode), 0);
  endtask

  task automatic pulse_credit();
    credit_man = 1'b1;
    @(posedge clk); #1;
    credit_man = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_rows = '0; cmd_cols = '0;
    fetch_ready = 1'b1; auto_credit = 1'b1; credit_man = 1'b0; stray_inj = 1'b0;
    tiles_allowed = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // EWM single op, 2x3
    push_op(1, 2, 3, 1'b0);
    send_cmd(1, 2, 3);
    check("first_fetch_valid", int'(fetch_valid), 1);
    check("busy_in_issue", int'({busy, cmd_ready}), 2);
    wait_idle("ewm_timeout");
    check("mode_hold_after_op", int'(arr_mode), 1);

    // MAC op with both tile pulses, then with one missing
    tiles_allowed = 2;
    push_op(0, 2, 16, 1'b0);
    send_cmd(0, 2, 16);
    wait_idle("mac_ok_timeout");
    tiles_allowed = 1;
    push_op(0, 2, 16, 1'b1);
    send_cmd(0, 2, 16);
    wait_idle("mac_short_timeout");
    tiles_allowed = 0;

    // Credit stall: no automatic returns
    auto_credit = 1'b0;
    push_op(3, 1, 4, 1'b0);
    send_cmd(3, 1, 4);
    repeat (6) begin @(posedge clk); #1; end
    check("stall_fetch_valid", int'(fetch_valid), 0);
    check("stall_remaining", exp_q.size(), 3);
    pulse_credit();
    repeat (4) begin @(posedge clk); #1; end
    check("one_credit_fetch_valid", int'(fetch_valid), 0);
    check("one_credit_remaining", exp_q.size(), 2);
    pulse_credit();
    wait_idle("stall_timeout");
    pulse_credit();
    pulse_credit();
    auto_credit = 1'b1;

    // Fetch backpressure 1,0,0,1
    push_op(2, 1, 4, 1'b0);
    send_cmd(2, 1, 4);
    @(posedge clk); #1;
    fetch_ready = 1'b0; #1;
    check("bp_hold_col_a", int'(fetch_col), 1);
    check("bp_req_held_a", int'({fetch_valid, arr_valid_in}), 2);
    @(posedge clk); #2;
    check("bp_hold_col_b", int'(fetch_col), 1);
    check("bp_hold_row_b", int'(fetch_row), 0);
    @(posedge clk); #1;
    fetch_ready = 1'b1;
    wait_idle("bp_timeout");

    // Bad and empty commands
    push_op(0, 1, 8, 1'b1);
    send_cmd(0, 1, 8);
    wait_idle("bad_mac_timeout");
    push_op(1, 0, 5, 1'b0);
    send_cmd(1, 0, 5);
    wait_idle("empty_rows_timeout");
    push_op(0, 3, 0, 1'b0);
    send_cmd(0, 3, 0);
    wait_idle("empty_cols_timeout");

    // Reset mid-operation, then a stray result in IDLE
    push_op(4, 2, 3, 1'b0);
    send_cmd(4, 2, 3);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    exp_q.delete();
    check_reset("mid_op_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    stray_inj = 1'b1;
    @(posedge clk); #1;
    stray_inj = 1'b0;
    @(posedge clk); #1;
    push_op(5, 1, 2, 1'b1);
    send_cmd(5, 1, 2);
    wait_idle("stray_op_timeout");
    push_op(6, 1, 2, 1'b0);
    send_cmd(6, 1, 2);
    wait_idle("clean_op_timeout");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tile_op_sequencer.md
# tile_op_sequencer

Per-operation controller for the four-array tile pipeline. It accepts one operation command (mode plus tile-grid size) and walks the grid in row-major order. For each beat it issues fetch requests to the access controller, gated by result-buffer credits, and drives the pipeline's `valid_in` and `mode`. It counts returning `valid_out` beats and MAC `done_tile` pulses, then signals operation completion or error. It sits between the layer-level scheduler (command source) and the pipeline plus access controller.

## Interface
- `COL_BLOCKS`, default 16: column blocks per MAC accumulation; must match the pipeline's internal constant.
- `ROW_W`, default 10: width of the row-tile count.
- `COL_W`, default 8: width of the column-block count.
- `CREDITS`, default 8: result-buffer depth, i.e. the maximum number of results in flight.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_mode`, in, 3: pipeline mode encoding 000–110.
- `cmd_rows`, in, `ROW_W`: number of row tiles.
- `cmd_cols`, in, `COL_W`: column blocks per row.
- `fetch_valid`, out, 1: tile-fetch request for the current beat.
- `fetch_ready`, in, 1: access controller presents tile data this cycle.
- `fetch_row`, out, `ROW_W`: row index of the current beat.
- `fetch_col`, out, `COL_W`: column index of the current beat.
- `arr_mode`, out, 3: pipeline mode, held stable for the whole operation.
- `arr_valid_in`, out, 1: pipeline `valid_in`; equals `fetch_valid & fetch_ready`.
- `arr_valid_out`, in, 1: pipeline result beat.
- `arr_done_tile`, in, 1: pipeline MAC tile-complete pulse.
- `credit_ret`, in, 1: result buffer freed one entry.
- `busy`, out, 1: operation in progress (any state other than IDLE).
- `op_done`, out, 1: one-cycle completion pulse.
- `op_err`, out, 1: qualifies `op_done`; high if the operation faulted.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- **IDLE.** `cmd_ready=1`. On handshake:
  - Latch mode, rows and cols.
  - Clear the issue, return and tile counters and the error flag.
  - If rows==0 or cols==0, go to DONE with no error.
  - If mode==000 and cols≠`COL_BLOCKS`, go to DONE with `op_err`. No beats are issued.
  - Otherwise go to ISSUE.
- **ISSUE.**
  - `fetch_valid=1` while credits>0.
  - On `arr_valid_in`:
    - issued++, credits--.
    - Advance col. When col wraps from cols-1 to 0, row++.
  - On the handshake of the last beat (row=rows-1, col=cols-1), go to DRAIN.
- **DRAIN.** `fetch_valid=0`. When returned==issued, go to DONE.
- **DONE.** Lasts one cycle. `op_done=1`, then go to IDLE.
- **Credits.** Start at `CREDITS` on reset. A `credit_ret` and an issue in the same cycle leave the count unchanged. The count saturates at `CREDITS`.
- **Return counting.**
  - `arr_valid_out` increments `returned` in ISSUE and DRAIN.
  - `arr_valid_out` in IDLE or DONE sets the sticky `stray` flag. `stray` is reported via `op_err` on the next `op_done` and then cleared.
- **MAC check.** In mode 000, `arr_done_tile` increments `tiles`. At DONE, `op_err` is also set if tiles≠rows.
- `arr_mode` updates only on command accept and holds its value after the operation, so the pipeline's output mux stays consistent while results drain.
- All counters are unsigned. Row and col indices wrap exactly at the latched limits. `issued` and `returned` are `ROW_W+COL_W` bits wide.

## Timing
- **Reset values:**
  - `cmd_ready=1`, `busy=0`, `fetch_valid=0`, `arr_valid_in=0`.
  - `fetch_row=0`, `fetch_col=0`, `arr_mode=000`.
  - `op_done=0`, `op_err=0`, credits=`CREDITS`, state=IDLE.
- Reset asserted mid-operation aborts immediately. No `op_done` is produced. In-flight pipeline results after reset count as stray.
- Command accept at edge N puts the FSM in ISSUE at N+1, so the first `fetch_valid` is visible in cycle N+1.
- Throughput is one beat per cycle while `fetch_ready=1` and credits>0.
- `fetch_row` and `fetch_col` are registered and change only on the edge following a handshake.
- `fetch_ready` may drop at any time. The request holds with unchanged indices.
- `op_done` is asserted in the cycle after the final return is counted.
- `cmd_ready=0` from ISSUE through DONE. A command offered during DONE waits until IDLE.

## Structure
- Package `tile_seq_pkg`:
  - state enum `seq_state_t`;
  - mode constants `MODE_MAC`, `MODE_EWM_MAT`, `MODE_EWM_VEC`, `MODE_EWM_OUT`, `MODE_EWA_VEC`, `MODE_EWA_MAT`, `MODE_EWM_MAT2`;
  - `COL_BLOCKS` default.
- Sub-module `seq_credit_ctr`: saturating up/down counter with `has_credit` output.

## Test plan
- **EWM single op.** mode=001, rows=2, cols=3, `fetch_ready`=1, fixed pipeline latency 1 → exactly 6 `arr_valid_in` beats with (row,col) (0,0)…(1,2), then `op_done` with `op_err=0`.
- **MAC op.** mode=000, rows=2, cols=16, `done_tile` pulsed after beats 16 and 32 → 32 beats, `op_done` with `op_err=0`. Repeat with only one `done_tile` pulse → `op_err=1`.
- **Credit stall.** `CREDITS`=2, no `credit_ret`, rows=1, cols=4 → exactly 2 beats issued, then `fetch_valid=0`. Return one credit → exactly one more beat.
- **Fetch backpressure.** `fetch_ready` toggled 1,0,0,1 → indices hold during low cycles and no beat is skipped or duplicated.
- **Bad and empty commands.** mode=000 with cols=8 → `op_done` + `op_err` with zero beats. rows=0 → `op_done`, `op_err=0`, zero beats.
- **Reset and stray results.** `rst` during ISSUE → all outputs at reset values the next cycle. A subsequent `arr_valid_out` in IDLE → the next operation ends with `op_err=1`.
